result_fifo_reader: RTL and testbench
=====================================

// Module: result_fifo_reader
// PURPOSE
//  Processor-side end of the result-stream path: accepts 64-bit results (data+valid) from the processing
//  chain, buffers them, and exposes them to the NIOS/HPS as an Avalon-MM slave of 32-bit registers.
//  Reading DATA_LO pops one entry and latches its upper half, so DATA_HI returns the same 64-bit sample.
//  Sits between the processing logic and the Qsys interconnect; replaces paired up/down 32-bit FIFOs.
// PARAMETERS
//  DEPTH      256  FIFO entries; power of 2, >= 4
//  IRQ_LEVEL  128  irq asserted while level >= IRQ_LEVEL; 1..DEPTH
// PORTS
//  clk            in   1   single clock for all logic
//  reset          in   1   asynchronous, active-high reset
//  in_data        in   64  result sample
//  in_valid       in   1   push strobe, one sample per high cycle; no backpressure
//  avs_address    in   2   register select: 0 DATA_LO, 1 DATA_HI, 2 STATUS, 3 CONTROL
//  avs_read       in   1   read strobe
//  avs_readdata   out  32  read data, valid exactly 1 cycle after avs_read
//  avs_write      in   1   write strobe; only CONTROL is writable
//  avs_writedata  in   32  write data
//  irq            out  1   level interrupt
// BEHAVIOUR
//  Reset: FIFO emptied, level=0, hi_hold=0, avs_readdata=0, overflow=0, underflow=0, irq=0.
//  Push: in_valid && (!full || pop_this_cycle) -> write in_data at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  in_valid && full && no pop -> sample dropped, overflow sticky set; FIFO contents unchanged.
//  Pop: avs_read && addr==0 && !empty -> next cycle readdata=entry[31:0], hi_hold<=entry[63:32], rd_ptr++.
//  avs_read addr0 while empty -> readdata=0, no pop, hi_hold unchanged, underflow sticky set.
//  addr1 read -> readdata=hi_hold; no side effects. Repeatable.
//  addr2 read -> {underflow[31], overflow[30], full[29], empty[28], 12'b0, level[15:0]}; no side effects.
//  addr3 read -> 0. Write addr3: bit0=flush (pointers and level to 0, hi_hold=0), bit1=clear overflow,
//   bit2=clear underflow. Writes to addr0..2 ignored.
//  Flush in the same cycle as a push: flush wins; the pushed sample is discarded, not counted as overflow.
//  Flush in the same cycle as a pop read: readdata returns the popped entry; FIFO is empty afterwards.
//  Push+pop when empty: pop sees empty (underflow, readdata 0); push accepted; level=1. No fall-through.
//  Push+pop when 0<level<DEPTH: level unchanged. Push+pop when full: both succeed, level stays DEPTH.
//  level width clog2(DEPTH)+1; full = (level==DEPTH); empty = (level==0); all flags registered.
//  irq registered: asserts the cycle after level reaches IRQ_LEVEL, deasserts the cycle after level drops below it.
//  Read latency fixed at 1 cycle; no waitrequest. Simultaneous read and write: both serviced.
//  Asynchronous reset mid-transfer: all state cleared immediately; a pending readdata is lost (reads as 0).
// STRUCTURE
//  Shared package result_fifo_pkg: register address constants (ADDR_DATA_LO..ADDR_CONTROL),
//   STATUS bit positions, CONTROL bit positions.
//  Sub-module sync_fifo (WIDTH=64, DEPTH): RAM array, wr/rd pointers, level, full/empty, push/pop/flush
//   inputs, registered read output. Top level holds the register decode, hi_hold, sticky flags and irq.
//  Storage must infer block RAM: registered read, no asynchronous read port.
// TESTING
//  1 Push 0x1111_2222_3333_4444 then read addr0, addr1 -> 0x3333_4444, 0x1111_2222; STATUS level=0, empty=1.
//  2 Push DEPTH+3 samples (0..258), no reads -> full=1, overflow=1, level=256; drain returns 0..255 in order.
//  3 Read addr0 when empty -> readdata=0, underflow=1; write CONTROL=0x4 -> underflow=0.
//  4 Fill to 255, then push and pop in the same cycle every cycle for 10 cycles -> level stays 255, order kept;
//    same at 256 (full) -> no overflow.
//  5 IRQ_LEVEL=128: push 127 -> irq=0; push 1 more -> irq=1 the next cycle; pop 1 -> irq=0 the next cycle.
//  6 Push 5 samples, write CONTROL=0x1 while in_valid=1 -> level=0, empty=1, overflow=0.
//    Assert reset mid-stream -> all outputs 0 at once.

Source files
------------

// File: rtl/result_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_fifo_pkg
//  Description : Shared register map for the result FIFO reader. It holds the
//                Avalon register addresses, the STATUS and CONTROL bit
//                positions, and a helper function that packs the STATUS word.
//  Revision    : 1.0  initial release
// ============================================================================
package result_fifo_pkg;

  // Register addresses (Avalon word address)
  localparam logic [1:0] ADDR_DATA_LO = 2'd0;
  localparam logic [1:0] ADDR_DATA_HI = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  // STATUS bit positions
  localparam int STAT_UNDERFLOW_BIT = 31;
  localparam int STAT_OVERFLOW_BIT  = 30;
  localparam int STAT_FULL_BIT      = 29;
  localparam int STAT_EMPTY_BIT     = 28;

  // CONTROL bit positions
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_CLR_UDF_BIT = 2;

  function automatic logic [31:0] status_word(
    input logic        udf,
    input logic        ovf,
    input logic        full,
    input logic        empty,
    input logic [15:0] level
  );
    logic [31:0] w;
    w                     = '0;
    w[STAT_UNDERFLOW_BIT] = udf;
    w[STAT_OVERFLOW_BIT]  = ovf;
    w[STAT_FULL_BIT]      = full;
    w[STAT_EMPTY_BIT]     = empty;
    w[15:0]               = level;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO whose storage array has a registered read
//                port only, so it can be mapped to block RAM. The level,
//                full and empty outputs are registered. Flush takes priority
//                over push. A pop that is issued together with a flush still
//                delivers its entry on rd_data.
//  Ports       : clk, rst (async, active-high)
//                push/wr_data  - write request; it is ignored when the FIFO
//                                is full, unless a pop is accepted in the
//                                same cycle
//                pop           - read request; it is ignored when the FIFO
//                                is empty
//                flush         - empty the FIFO
//                rd_data       - popped entry, valid the cycle after the pop
//                level/full/empty - registered occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [LW-1:0]    level_nxt;

  assign pop_ok  = pop && !empty;
  // When the FIFO is full and a pop is accepted, the write reuses the slot
  // that the read frees in the same cycle.
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      level_nxt = level + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage has no reset. The read is registered and reads the old data
  // first, which matters when the FIFO is full and pushes and pops together.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
    if (pop_ok) begin
      rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_L);
      empty <= (level_nxt == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : result_fifo_reader
//  Description : Buffers 64-bit result samples and presents them to the
//                processor as 32-bit Avalon-MM registers. A read of DATA_LO
//                pops one entry and latches that entry's upper half for
//                DATA_HI.
//  Ports       : clk, reset (async, active-high)
//                in_data/in_valid      - sample stream, no backpressure
//                avs_address/read/write/writedata/readdata
//                                      - register port, fixed read latency
//                                        of 1 cycle
//                irq                   - level interrupt, high while
//                                        level >= IRQ_LEVEL
//  Revision    : 1.0  initial release
// ============================================================================
module result_fifo_reader
  import result_fifo_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int IRQ_LEVEL = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] IRQ_LVL = LW'(IRQ_LEVEL);

  logic [63:0]   fifo_rd_data;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;

  logic          pop_req;
  logic          pop_ok;
  logic          wr_ctrl;
  logic          flush;
  logic          clr_ovf;
  logic          clr_udf;
  logic          ovf_evt;
  logic          udf_evt;

  logic          pop_pending;
  logic [31:0]   reg_rdata;
  logic [31:0]   rdata_nxt;
  logic [31:0]   hi_hold;
  logic [31:0]   hi_cur;
  logic          overflow;
  logic          underflow;

  logic          unused_wdata;
  assign unused_wdata = ^avs_writedata[31:3];

  assign pop_req = avs_read && (avs_address == ADDR_DATA_LO);
  assign pop_ok  = pop_req && !empty;
  assign udf_evt = pop_req && empty;
  assign wr_ctrl = avs_write && (avs_address == ADDR_CONTROL);
  assign flush   = wr_ctrl && avs_writedata[CTRL_FLUSH_BIT];
  assign clr_ovf = wr_ctrl && avs_writedata[CTRL_CLR_OVF_BIT];
  assign clr_udf = wr_ctrl && avs_writedata[CTRL_CLR_UDF_BIT];
  // A push dropped during a flush is not an overflow. The push is discarded
  // on purpose.
  assign ovf_evt = in_valid && full && !pop_ok && !flush;

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (pop_req),
    .flush   (flush),
    .rd_data (fifo_rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // The RAM output is not ready until the cycle after a pop, so hi_hold is
  // loaded one cycle late. A DATA_HI read issued in that cycle takes the
  // upper half straight from the RAM output instead.
  assign hi_cur = pop_pending ? fifo_rd_data[63:32] : hi_hold;

  always_comb begin
    rdata_nxt = '0;
    if (avs_read) begin
      unique case (avs_address)
        ADDR_DATA_HI: rdata_nxt = hi_cur;
        ADDR_STATUS:  rdata_nxt = status_word(underflow, overflow, full, empty, 16'(level));
        default:      rdata_nxt = '0;
      endcase
    end
  end

  // A popped DATA_LO comes directly from the RAM output register. All other
  // reads come from reg_rdata.
  assign avs_readdata = pop_pending ? fifo_rd_data[31:0] : reg_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_pending <= 1'b0;
      reg_rdata   <= '0;
      hi_hold     <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      pop_pending <= pop_ok;
      reg_rdata   <= rdata_nxt;

      if (flush) begin
        hi_hold <= '0;
      end else if (pop_pending) begin
        hi_hold <= fifo_rd_data[63:32];
      end

      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      if (udf_evt) begin
        underflow <= 1'b1;
      end else if (clr_udf) begin
        underflow <= 1'b0;
      end

      irq <= (level >= IRQ_LVL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_fifo_reader
//  Description : Self-checking bench for result_fifo_reader. It uses a
//                queue-based reference model, a vector table, hand-written
//                corner sequences and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_result_fifo_reader;

  localparam int DEPTH     = 256;
  localparam int IRQ_LEVEL = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_valid;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;

  always #5 clk = ~clk;

  result_fifo_reader #(
    .DEPTH     (DEPTH),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .irq           (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] m_hi;
  bit          m_ovf;
  bit          m_udf;
  logic [31:0] m_rdata;
  bit          m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_hi    = '0;
    m_ovf   = 0;
    m_udf   = 0;
    m_rdata = '0;
    m_irq   = 0;
  endtask

  // Advances the model by one clock edge, using the inputs that were
  // presented before that edge.
  task automatic model_edge(input bit v, input logic [63:0] d, input bit rd,
                            input logic [1:0] a, input bit wr, input logic [31:0] wd);
    int          sz;
    logic [63:0] e;
    logic [31:0] rdv;
    bit          fl;
    bit          ovf_set;
    bit          udf_set;
    bit          popped;
    sz      = mq.size();
    e       = '0;
    rdv     = '0;
    ovf_set = 0;
    udf_set = 0;
    popped  = 0;
    fl      = wr && (a == 2'd3) && wd[0];
    m_irq   = (sz >= IRQ_LEVEL);
    if (rd) begin
      case (a)
        2'd0: begin
          if (sz > 0) begin
            e      = mq.pop_front();
            rdv    = e[31:0];
            popped = 1;
          end else begin
            udf_set = 1;
          end
        end
        2'd1:    rdv = m_hi;
        2'd2:    rdv = {m_udf, m_ovf, (sz == DEPTH), (sz == 0), 12'b0, 16'(sz)};
        default: rdv = '0;
      endcase
    end
    if (v && !fl) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else ovf_set = 1;
    end
    if (fl) begin
      mq.delete();
      m_hi = '0;
    end
    if (popped) m_hi = e[63:32];
    if (wr && (a == 2'd3) && wd[1]) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
    if (wr && (a == 2'd3) && wd[2]) m_udf = 0;
    if (udf_set) m_udf = 1;
    m_rdata = rdv;
  endtask

  // Drives one cycle, advances the model, and compares readdata and irq
  // 1 ns after the edge.
  task automatic cycle(input bit v, input logic [63:0] d, input bit rd,
                       input logic [1:0] a, input bit wr, input logic [31:0] wd);
    in_valid      = v;
    in_data       = d;
    avs_read      = rd;
    avs_address   = a;
    avs_write     = wr;
    avs_writedata = wd;
    @(posedge clk);
    model_edge(v, d, rd, a, wr, wd);
    #1;
    in_valid  = 1'b0;
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check("model_readdata", avs_readdata, m_rdata);
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic push(input logic [63:0] d);
    cycle(1, d, 0, 2'd0, 0, '0);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(0, '0, 1, a, 0, '0);
  endtask

  task automatic ctrl(input logic [31:0] w);
    cycle(0, '0, 0, 2'd3, 1, w);
  endtask

  task automatic idle();
    cycle(0, '0, 0, 2'd0, 0, '0);
  endtask

  typedef struct {
    bit          v;
    logic [63:0] d;
    bit          rd;
    logic [1:0]  a;
    bit          wr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[11];

  bit          rv;
  bit          rr;
  bit          rw;
  logic [1:0]  ra;
  logic [31:0] rwd;
  int          push_pct;
  int          read_pct;

  initial begin
    tbl[0]  = '{1, 64'h1111_2222_3333_4444, 0, 2'd0, 0, 32'h0,         32'h0};
    tbl[1]  = '{0, 64'h0,                   1, 2'd0, 0, 32'h0,         32'h3333_4444};
    tbl[2]  = '{0, 64'h0,                   1, 2'd1, 0, 32'h0,         32'h1111_2222};
    tbl[3]  = '{0, 64'h0,                   1, 2'd2, 0, 32'h0,         32'h1000_0000};
    tbl[4]  = '{0, 64'h0,                   1, 2'd0, 0, 32'h0,         32'h0};
    tbl[5]  = '{0, 64'h0,                   1, 2'd2, 0, 32'h0,         32'h9000_0000};
    tbl[6]  = '{0, 64'h0,                   0, 2'd3, 1, 32'h4,         32'h0};
    tbl[7]  = '{0, 64'h0,                   1, 2'd2, 0, 32'h0,         32'h1000_0000};
    tbl[8]  = '{0, 64'h0,                   0, 2'd1, 1, 32'hDEAD_BEEF, 32'h0};
    tbl[9]  = '{0, 64'h0,                   1, 2'd1, 0, 32'h0,         32'h1111_2222};
    tbl[10] = '{0, 64'h0,                   1, 2'd3, 0, 32'h0,         32'h0};

    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    avs_read      = 1'b0;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", avs_readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    rd(2'd2);
    check("reset_status", avs_readdata, 32'h1000_0000);

    // Vector table: basic push/pop, DATA_HI, underflow and ignored writes
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].a, tbl[i].wr, tbl[i].wd);
      check($sformatf("tbl_rdata[%0d]", i), avs_readdata, tbl[i].exp_rdata);
    end

    // Overfill by 3 samples, then drain in order
    for (int i = 0; i < DEPTH + 3; i++) push(64'(i));
    rd(2'd2);
    check("ovf_status", avs_readdata, 32'h6000_0100);
    for (int i = 0; i < DEPTH; i++) begin
      rd(2'd0);
      check("drain", avs_readdata, 32'(i));
    end
    rd(2'd2);
    check("drained_status", avs_readdata, 32'h5000_0000);
    ctrl(32'h2);
    rd(2'd2);
    check("ovf_cleared", avs_readdata, 32'h1000_0000);

    // Push and pop together at level DEPTH-1, then at full
    ctrl(32'h7);
    for (int i = 0; i < DEPTH - 1; i++) push(64'(1000 + i));
    rd(2'd2);
    check("lvl255_status", avs_readdata, 32'h0000_00FF);
    for (int k = 0; k < 10; k++) begin
      cycle(1, 64'(2000 + k), 1, 2'd0, 0, '0);
      check("pp255_order", avs_readdata, 32'(1000 + k));
    end
    rd(2'd2);
    check("pp255_level", avs_readdata, 32'h0000_00FF);
    push(64'd3000);
    for (int k = 0; k < 10; k++) begin
      cycle(1, 64'(4000 + k), 1, 2'd0, 0, '0);
      check("ppfull_order", avs_readdata, 32'(1010 + k));
    end
    rd(2'd2);
    check("ppfull_status", avs_readdata, 32'h2000_0100);

    // IRQ threshold
    ctrl(32'h1);
    idle();
    for (int i = 0; i < IRQ_LEVEL - 1; i++) push(64'(i));
    idle();
    check("irq_below", {31'b0, irq}, 32'h0);
    push(64'h77);
    check("irq_same_cycle", {31'b0, irq}, 32'h0);
    idle();
    check("irq_set", {31'b0, irq}, 32'h1);
    rd(2'd0);
    check("irq_pop_cycle", {31'b0, irq}, 32'h1);
    idle();
    check("irq_clear", {31'b0, irq}, 32'h0);

    // Flush that collides with a push
    ctrl(32'h7);
    for (int i = 0; i < 5; i++) push(64'(i));
    cycle(1, 64'hABCD, 0, 2'd3, 1, 32'h1);
    rd(2'd2);
    check("flush_push_status", avs_readdata, 32'h1000_0000);

    // Asynchronous reset while a read response is on the bus
    for (int i = 0; i < 130; i++) push({32'hCAFE_0000, 32'(i + 1)});
    idle();
    idle();
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    rd(2'd0);
    check("pre_reset_rdata", avs_readdata, 32'h1);
    reset = 1'b1;
    #1;
    check("async_reset_rdata", avs_readdata, 32'h0);
    check("async_reset_irq", {31'b0, irq}, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(2'd2);
    check("post_reset_status", avs_readdata, 32'h1000_0000);
    rd(2'd1);
    check("post_reset_hi", avs_readdata, 32'h0);

    // Randomized traffic compared against the model
    for (int blk = 0; blk < 6; blk++) begin
      push_pct = (blk % 2 == 0) ? 60 : 30;
      read_pct = (blk % 2 == 0) ? 35 : 65;
      for (int i = 0; i < 500; i++) begin
        rv  = ($urandom_range(99) < push_pct);
        rr  = ($urandom_range(99) < read_pct);
        ra  = ($urandom_range(99) < 70) ? 2'd0 : 2'($urandom_range(3));
        rw  = ($urandom_range(99) < 4);
        rwd = $urandom() & 32'h0000_0006;
        if ($urandom_range(7) == 0) rwd[0] = 1'b1;
        cycle(rv, {$urandom(), $urandom()}, rr, ra, rw, rwd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
